// File: rtl/bank_write_control_if.sv
// Stream-in / bank-write-out bundle for bank_write_control.
// master = header finder and readout side, slave = the writer itself.
interface bank_write_control_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_BANKS    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
);
  logic                                 get_package;
  logic [DATA_WIDTH-1:0]                input_data;
  logic [N_BANKS-1:0]                   wr_en;
  logic [N_BANKS-1:0][ADDR_WIDTH-1:0]   wr_addr;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0]   wr_data;
  logic                                 valid;
  logic                                 busy;
  logic                                 pkg_done;
  logic                                 pkg_abort;
  logic [ADDR_WIDTH-1:0]                pkg_start_addr;
  logic [CNT_WIDTH-1:0]                 pkg_count;

  modport master (
    output get_package, input_data,
    input  wr_en, wr_addr, wr_data, valid, busy, pkg_done, pkg_abort,
           pkg_start_addr, pkg_count
  );

  modport slave (
    input  get_package, input_data,
    output wr_en, wr_addr, wr_data, valid, busy, pkg_done, pkg_abort,
           pkg_start_addr, pkg_count
  );
endinterface

// File: rtl/bank_write_control.sv
// Round-robin package writer: spreads a fixed-length word stream over N_BANKS
// circular-buffer RAMs, with abort rollback, done/abort pulses and a package counter.
module bank_write_lane #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 15,
  parameter int MEMORY_DEPTH = 24576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  snap,
  input  logic                  restore,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, rb_q, rb_d, nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;

  assign nxt = (ptr_q == LAST) ? '0 : ptr_q + ADDR_WIDTH'(1);

  // Snapshot takes the post-update pointer so a back-to-back start sees the
  // last word's write and an abort restart keeps the restored pointer.
  always_comb begin
    ptr_d     = ptr_q;
    rb_d      = rb_q;
    wr_en_d   = wr;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (restore) begin
      ptr_d = rb_q;
    end else if (wr) begin
      ptr_d     = nxt;
      wr_addr_d = nxt;
      wr_data_d = din;
    end
    if (snap) rb_d = ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= LAST;
      rb_q      <= LAST;
      wr_en_q   <= 1'b0;
      wr_addr_q <= LAST;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rb_q      <= rb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

module bank_write_control #(
  parameter int DATA_WIDTH     = 16,
  parameter int N_BANKS        = 2,
  parameter int PACKAGE_LENGTH = 1036,
  parameter int MEMORY_DEPTH   = 24576,
  parameter int ADDR_WIDTH     = 15,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 live_rising,
  bank_write_control_if.slave  bus
);
  localparam int KW  = (PACKAGE_LENGTH > 1) ? $clog2(PACKAGE_LENGTH) : 1;
  localparam int BW  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  // Bank 0 receives ceil(PL/N) words per package; its start address advances by that.
  localparam int W0M = ((PACKAGE_LENGTH + N_BANKS - 1) / N_BANKS) % MEMORY_DEPTH;
  localparam logic [ADDR_WIDTH:0] W0M_V = (ADDR_WIDTH+1)'(W0M);
  localparam logic [ADDR_WIDTH:0] MD_V  = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [BW-1:0]         bank_q, bank_d;
  logic                  done_q, done_d, abort_q, abort_d, take;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d, nb_q, nb_d;
  logic [ADDR_WIDTH:0]   nb_sum, nb_wrap;
  logic                  last;

  logic [N_BANKS-1:0]                 en_w;
  logic [N_BANKS-1:0][ADDR_WIDTH-1:0] addr_w;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0] data_w;

  assign last    = (k_q == KW'(PACKAGE_LENGTH - 1));
  assign nb_sum  = {1'b0, nb_q} + W0M_V;
  assign nb_wrap = (nb_sum >= MD_V) ? nb_sum - MD_V : nb_sum;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    cnt_d   = cnt_q;
    start_d = start_q;
    nb_d    = nb_q;
    take    = 1'b0;
    if (state_q == RUN) begin
      if (bus.get_package && !last) begin
        abort_d = 1'b1;
      end else begin
        take = 1'b1;
        if (last) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          start_d = nb_q;
          nb_d    = ADDR_WIDTH'(nb_wrap);
          state_d = IDLE;
        end else begin
          k_d    = k_q + KW'(1);
          bank_d = (bank_q == BW'(N_BANKS - 1)) ? '0 : bank_q + BW'(1);
        end
      end
    end
    if (bus.get_package) begin
      state_d = RUN;
      k_d     = '0;
      bank_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (live_rising) begin
      state_q <= IDLE;
      k_q     <= '0;
      bank_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      start_q <= '0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      nb_q    <= nb_d;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    bank_write_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH)
    ) u_lane (
      .clk     (clk),
      .rst     (live_rising),
      .wr      (take && (bank_q == BW'(b))),
      .snap    (bus.get_package),
      .restore (abort_d),
      .din     (bus.input_data),
      .wr_en   (en_w[b]),
      .wr_addr (addr_w[b]),
      .wr_data (data_w[b])
    );
  end

  assign bus.wr_en          = en_w;
  assign bus.wr_addr        = addr_w;
  assign bus.wr_data        = data_w;
  assign bus.valid          = |en_w;
  assign bus.busy           = (state_q == RUN);
  assign bus.pkg_done       = done_q;
  assign bus.pkg_abort      = abort_q;
  assign bus.pkg_start_addr = start_q;
  assign bus.pkg_count      = cnt_q;
endmodule

// File: tb/tb_bank_write_control.sv
// Three writers (default, 3-bank uneven, 8-deep wrap) checked every cycle
// against a package/address-arithmetic reference model.
module tb_bank_write_control;
  localparam int NB  [3] = '{2, 3, 2};
  localparam int PLA [3] = '{1036, 5, 6};
  localparam int MDA [3] = '{24576, 24576, 8};

  typedef struct packed {
    logic [2:0]       en;
    logic [2:0][14:0] addr;
    logic [2:0][15:0] data;
    logic             valid, busy, done, abort;
    logic [14:0]      start;
    logic [15:0]      cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  gp  = '0;
  logic [15:0] din = '0;

  int   checks = 0;
  int   errors = 0;
  bit   run_m [3];
  int   k_m   [3];
  int   cnt_m [3];
  int   cbase [3][3];
  obs_t exp_s [3];

  always #5 clk = ~clk;

  bank_write_control_if #(.DATA_WIDTH(16), .N_BANKS(2), .ADDR_WIDTH(15), .CNT_WIDTH(16)) if0 ();
  bank_write_control_if #(.DATA_WIDTH(16), .N_BANKS(3), .ADDR_WIDTH(15), .CNT_WIDTH(16)) if1 ();
  bank_write_control_if #(.DATA_WIDTH(16), .N_BANKS(2), .ADDR_WIDTH(15), .CNT_WIDTH(16)) if2 ();

  assign if0.get_package = gp[0];
  assign if1.get_package = gp[1];
  assign if2.get_package = gp[2];
  assign if0.input_data  = din;
  assign if1.input_data  = din;
  assign if2.input_data  = din;

  bank_write_control #(.DATA_WIDTH(16), .N_BANKS(2), .PACKAGE_LENGTH(1036),
    .MEMORY_DEPTH(24576), .ADDR_WIDTH(15), .CNT_WIDTH(16))
    dut0 (.clk(clk), .live_rising(rst), .bus(if0));
  bank_write_control #(.DATA_WIDTH(16), .N_BANKS(3), .PACKAGE_LENGTH(5),
    .MEMORY_DEPTH(24576), .ADDR_WIDTH(15), .CNT_WIDTH(16))
    dut1 (.clk(clk), .live_rising(rst), .bus(if1));
  bank_write_control #(.DATA_WIDTH(16), .N_BANKS(2), .PACKAGE_LENGTH(6),
    .MEMORY_DEPTH(8), .ADDR_WIDTH(15), .CNT_WIDTH(16))
    dut2 (.clk(clk), .live_rising(rst), .bus(if2));

  // Word j of a package lands in bank j%N at (committed words of that bank + j/N) mod depth.
  task automatic step(input int i, input bit r, input bit g, input logic [15:0] d);
    int n, pl, md, j, b;
    obs_t e;
    n = NB[i]; pl = PLA[i]; md = MDA[i];
    if (r) begin
      run_m[i] = 0; k_m[i] = 0; cnt_m[i] = 0;
      e = '0;
      for (int bb = 0; bb < 3; bb++) begin
        cbase[i][bb] = 0;
        if (bb < n) e.addr[bb] = 15'(md - 1);
      end
      exp_s[i] = e;
      return;
    end
    e = exp_s[i];
    e.en = '0; e.done = 1'b0; e.abort = 1'b0;
    if (run_m[i]) begin
      j = k_m[i];
      if (g && j != pl - 1) begin
        e.abort = 1'b1;
      end else begin
        b = j % n;
        e.en[b]   = 1'b1;
        e.addr[b] = 15'((cbase[i][b] + j / n) % md);
        e.data[b] = d;
        if (j == pl - 1) begin
          e.done  = 1'b1;
          cnt_m[i]++;
          e.cnt   = 16'(cnt_m[i]);
          e.start = 15'(cbase[i][0]);
          for (int bb = 0; bb < n; bb++)
            cbase[i][bb] = (cbase[i][bb] + (pl - bb + n - 1) / n) % md;
          run_m[i] = 0;
        end else begin
          k_m[i] = j + 1;
        end
      end
    end
    if (g) begin run_m[i] = 1; k_m[i] = 0; end
    e.busy  = run_m[i];
    e.valid = |e.en;
    exp_s[i] = e;
  endtask

  function automatic obs_t get_obs(input int i);
    obs_t o = '0;
    case (i)
      0: begin
        o.en[1:0] = if0.wr_en; o.addr[1:0] = if0.wr_addr; o.data[1:0] = if0.wr_data;
        o.valid = if0.valid; o.busy = if0.busy; o.done = if0.pkg_done; o.abort = if0.pkg_abort;
        o.start = if0.pkg_start_addr; o.cnt = if0.pkg_count;
      end
      1: begin
        o.en = if1.wr_en; o.addr = if1.wr_addr; o.data = if1.wr_data;
        o.valid = if1.valid; o.busy = if1.busy; o.done = if1.pkg_done; o.abort = if1.pkg_abort;
        o.start = if1.pkg_start_addr; o.cnt = if1.pkg_count;
      end
      default: begin
        o.en[1:0] = if2.wr_en; o.addr[1:0] = if2.wr_addr; o.data[1:0] = if2.wr_data;
        o.valid = if2.valid; o.busy = if2.busy; o.done = if2.pkg_done; o.abort = if2.pkg_abort;
        o.start = if2.pkg_start_addr; o.cnt = if2.pkg_count;
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] ob, input logic [63:0] ex);
    checks++;
    assert (ob === ex)
      else begin
        errors++;
        $error("FAIL %s dut%0d observed %0h expected %0h", tag, i, ob, ex);
      end
  endtask

  task automatic cyc();
    obs_t o, e;
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(i, rst, gp[i], din);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      e = exp_s[i];
      chk("wr_en",   i, 64'(o.en),    64'(e.en));
      chk("wr_addr", i, 64'(o.addr),  64'(e.addr));
      chk("wr_data", i, 64'(o.data),  64'(e.data));
      chk("valid",   i, 64'(o.valid), 64'(e.valid));
      chk("busy",    i, 64'(o.busy),  64'(e.busy));
      chk("done",    i, 64'(o.done),  64'(e.done));
      chk("abort",   i, 64'(o.abort), 64'(e.abort));
      chk("start",   i, 64'(o.start), 64'(e.start));
      chk("count",   i, 64'(o.cnt),   64'(e.cnt));
    end
  endtask

  task automatic pulse(input int i);
    gp[i] = 1'b1; din = 16'($urandom); cyc(); gp[i] = 1'b0;
  endtask

  task automatic feed(input int n, input bit seq, input int base);
    for (int w = 0; w < n; w++) begin
      din = seq ? 16'(base + w) : 16'($urandom);
      cyc();
    end
  endtask

  task automatic idle(input int n);
    for (int w = 0; w < n; w++) begin din = 16'($urandom); cyc(); end
  endtask

  initial begin
    // reset
    rst = 1'b1; idle(2); rst = 1'b0;
    chk("rst_count", 0, 64'(if0.pkg_count), 64'd0);
    chk("rst_addr", 0, 64'(if0.wr_addr), {34'd0, 15'd24575, 15'd24575});

    // basic split, words 0..1035
    pulse(0); feed(1036, 1'b1, 0); idle(3);
    chk("basic_count", 0, 64'(if0.pkg_count), 64'd1);
    chk("basic_start", 0, 64'(if0.pkg_start_addr), 64'd0);

    // uneven split on three banks
    pulse(1); feed(5, 1'b0, 0); idle(2);
    pulse(1); feed(5, 1'b0, 0); idle(2);
    chk("uneven_count", 1, 64'(if1.pkg_count), 64'd2);
    chk("uneven_start", 1, 64'(if1.pkg_start_addr), 64'd2);

    // wrap of an 8-deep buffer over four packages
    for (int p = 0; p < 4; p++) begin pulse(2); feed(6, 1'b0, 0); idle(1); end
    chk("wrap_count", 2, 64'(if2.pkg_count), 64'd4);
    chk("wrap_start", 2, 64'(if2.pkg_start_addr), 64'd1);

    // abort at word 10, then back-to-back on the last word
    rst = 1'b1; idle(1); rst = 1'b0;
    pulse(0); feed(10, 1'b1, 0);
    gp[0] = 1'b1; din = 16'd10; cyc(); gp[0] = 1'b0;
    chk("abort_pulse", 0, 64'(if0.pkg_abort), 64'd1);
    feed(1035, 1'b1, 0);
    gp[0] = 1'b1; din = 16'd1035; cyc(); gp[0] = 1'b0;
    chk("b2b_done", 0, 64'(if0.pkg_done), 64'd1);
    chk("b2b_noabort", 0, 64'(if0.pkg_abort), 64'd0);
    chk("abort_count", 0, 64'(if0.pkg_count), 64'd1);
    feed(1036, 1'b1, 2000); idle(2);
    chk("b2b_count", 0, 64'(if0.pkg_count), 64'd2);
    chk("b2b_start", 0, 64'(if0.pkg_start_addr), 64'd518);

    // reset mid-package, coincident with a header
    pulse(0); feed(100, 1'b1, 0);
    rst = 1'b1; gp[0] = 1'b1; din = 16'd100; cyc(); rst = 1'b0; gp[0] = 1'b0;
    chk("rstmid_busy", 0, 64'(if0.busy), 64'd0);
    chk("rstmid_count", 0, 64'(if0.pkg_count), 64'd0);
    idle(2);
    pulse(0); feed(1036, 1'b0, 0); idle(2);
    chk("rstmid_start", 0, 64'(if0.pkg_start_addr), 64'd0);
    chk("rstmid_after", 0, 64'(if0.pkg_count), 64'd1);

    // randomized headers, aborts, back-to-back starts and rare resets
    for (int c = 0; c < 3000; c++) begin
      gp[0] = ($urandom_range(0, 399) == 0);
      gp[1] = ($urandom_range(0, 3) == 0);
      gp[2] = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      din   = 16'($urandom);
      cyc();
    end
    gp = '0; rst = 1'b0; idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
